apb_multi_timer: RTL and testbench

Parametrised multi-channel APB down-counter timer, the next generation of the single-channel APB timer in the peripheral subsystem. It provides NUM_CH independent channels of CNT_W bits. Each channel supports periodic or one-shot mode, an external enable or external clock, and an optional shared prescaler. Each channel has a per-channel interrupt and there is one combined interrupt. It sits on the peripheral APB bus beside the UART and GPIO and drives the interrupt controller.

---
 rtl/apb_multi_timer.sv | 147 ++++++++++++++
 tb/tb_apb_multi_timer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_timer.sv
// Multi-channel APB down-counter timer: NUM_CH channels of CNT_W bits, periodic or
// one-shot, external enable/clock per channel, shared prescaler and level interrupts.
module apb_multi_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic [11:2]       PADDR,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [NUM_CH-1:0] EXTIN,
  output logic [NUM_CH-1:0] TIMERINT,
  output logic              TIMERINT_ANY
);
  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_CURR    = 2'd1;
  localparam logic [1:0] OFF_RELOAD  = 2'd2;
  localparam logic [1:0] OFF_INTSTAT = 2'd3;

  logic       access, wr, rd;
  logic [3:0] ch_idx;
  logic [1:0] reg_off;
  logic       ch_hit, presc_sel, intall_sel, mapped;

  assign access     = PSEL & PENABLE;
  assign wr         = access & PWRITE;
  assign rd         = access & ~PWRITE;
  assign ch_idx     = PADDR[7:4];
  assign reg_off    = PADDR[3:2];
  assign ch_hit     = (PADDR[11:8] == 4'd0) && (int'(ch_idx) < NUM_CH);
  assign presc_sel  = (PADDR == 10'h040);
  assign intall_sel = (PADDR == 10'h041);
  assign mapped     = ch_hit | presc_sel | intall_sel;

  assign PREADY  = 1'b1;
  assign PSLVERR = access & ~mapped;

  // Write data bits above the register widths are deliberately dropped.
  logic unused_pwdata;
  assign unused_pwdata = &{1'b0, PWDATA};

  logic [PRESC_W-1:0] prescale, presc_cnt;
  logic               ptick;

  assign ptick = (presc_cnt == prescale);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      prescale  <= '0;
      presc_cnt <= '0;
    end else if (wr && presc_sel) begin
      prescale  <= PWDATA[PRESC_W-1:0];
      presc_cnt <= '0;
    end else begin
      presc_cnt <= ptick ? '0 : presc_cnt + PRESC_W'(1);
    end
  end

  // EXTIN stage boundary: _p0/_p1 synchronise, _p2 delays for edge detection.
  logic [NUM_CH-1:0] ext_p0, ext_p1, ext_p2, ext_rise;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ext_p0 <= '0;
      ext_p1 <= '0;
      ext_p2 <= '0;
    end else begin
      ext_p0 <= EXTIN;
      ext_p1 <= ext_p0;
      ext_p2 <= ext_p1;
    end
  end

  assign ext_rise = ext_p1 & ~ext_p2;

  logic [31:0] rdata_ch [NUM_CH];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [5:0]       ctrl;
    logic [CNT_W-1:0] curr, reload;
    logic             intstat;
    logic             sel, curr_wr, tick, expire;
    logic [31:0]      rdata;

    assign sel     = wr && ch_hit && (ch_idx == 4'(n));
    assign curr_wr = sel && (reg_off == OFF_CURR);
    assign tick    = ctrl[0] && (!ctrl[1] || ext_p1[n]) && (!ctrl[2] || ext_rise[n])
                     && (!ctrl[5] || ptick);
    // A CURR write in the same cycle swallows the tick, including its interrupt.
    assign expire  = tick && (curr == CNT_W'(1)) && !curr_wr;

    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        ctrl    <= '0;
        curr    <= '0;
        reload  <= '0;
        intstat <= 1'b0;
      end else begin
        if (sel && reg_off == OFF_CTRL) ctrl <= PWDATA[5:0];
        else if (expire && ctrl[4])      ctrl[0] <= 1'b0;

        if (curr_wr)   curr <= PWDATA[CNT_W-1:0];
        else if (tick) curr <= (curr == '0) ? reload : curr - CNT_W'(1);

        if (sel && reg_off == OFF_RELOAD) reload <= PWDATA[CNT_W-1:0];

        if (expire)                                          intstat <= 1'b1;
        else if (sel && reg_off == OFF_INTSTAT && PWDATA[0]) intstat <= 1'b0;
      end
    end

    always_comb begin
      rdata = '0;
      case (reg_off)
        OFF_CTRL:   rdata = 32'(ctrl);
        OFF_CURR:   rdata = 32'(curr);
        OFF_RELOAD: rdata = 32'(reload);
        default:    rdata = 32'(intstat);
      endcase
    end

    assign rdata_ch[n] = rdata;
    assign TIMERINT[n] = intstat & ctrl[3];
  end

  assign TIMERINT_ANY = |TIMERINT;

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      if (presc_sel)       PRDATA = 32'(prescale);
      else if (intall_sel) PRDATA = 32'(TIMERINT);
      else if (ch_hit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) PRDATA = rdata_ch[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_multi_timer.sv
// Scoreboard bench for apb_multi_timer: directed scenarios plus random APB traffic,
// checked against a behavioural model of the timer registers.
module tb_apb_multi_timer;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PW  = 4;
  localparam int unsigned MASK  = (1 << CW) - 1;
  localparam int unsigned PMASK = (1 << PW) - 1;

  logic           PCLK = 1'b0;
  logic           PRESETn = 1'b0;
  logic           PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:2]    PADDR = '0;
  logic [31:0]    PWDATA = '0;
  logic [31:0]    PRDATA;
  logic           PREADY, PSLVERR;
  logic [NCH-1:0] EXTIN = '0;
  logic [NCH-1:0] TIMERINT;
  logic           TIMERINT_ANY;

  apb_multi_timer #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .EXTIN(EXTIN), .TIMERINT(TIMERINT), .TIMERINT_ANY(TIMERINT_ANY)
  );

  always #5 PCLK = ~PCLK;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] sb [$];
  logic [32:0] mon_e;

  // Reference model state
  int unsigned m_curr [NCH];
  int unsigned m_reload [NCH];
  logic [5:0]  m_ctrl [NCH];
  bit          m_ist [NCH];
  int unsigned m_presc, m_pcnt;
  logic [NCH-1:0] m_s1, m_s2, m_d;

  function automatic logic [NCH-1:0] m_tint();
    logic [NCH-1:0] t;
    t = '0;
    for (int n = 0; n < NCH; n++) t[n] = m_ist[n] && m_ctrl[n][3];
    return t;
  endfunction

  // Returns {pslverr, prdata} for a read at byte address ba.
  function automatic logic [32:0] model_read(input logic [11:0] ba);
    int ch;
    ch = int'(ba >> 4);
    if (ba == 12'h100) return {1'b0, 32'(m_presc)};
    if (ba == 12'h104) return {1'b0, 32'(m_tint())};
    if (ba < 12'h100 && ch < NCH) begin
      case (ba[3:2])
        2'd0:    return {1'b0, 26'd0, m_ctrl[ch]};
        2'd1:    return {1'b0, 32'(m_curr[ch])};
        2'd2:    return {1'b0, 32'(m_reload[ch])};
        default: return {1'b0, 31'd0, m_ist[ch]};
      endcase
    end
    return {1'b1, 32'd0};
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int n = 0; n < NCH; n++) begin
        m_curr[n] <= 0; m_reload[n] <= 0; m_ctrl[n] <= '0; m_ist[n] <= 1'b0;
      end
      m_presc <= 0; m_pcnt <= 0;
      m_s1 <= '0; m_s2 <= '0; m_d <= '0;
    end else begin
      automatic bit wr_now = PSEL && PENABLE && PWRITE;
      automatic bit ptick  = (m_pcnt == m_presc);
      for (int n = 0; n < NCH; n++) begin
        automatic bit hit   = wr_now && ({PADDR, 2'b00} < 12'h100) && (PADDR[7:4] == n);
        automatic int off   = int'(PADDR[3:2]);
        automatic bit rise  = m_s2[n] && !m_d[n];
        automatic bit tick  = m_ctrl[n][0] && (!m_ctrl[n][1] || m_s2[n])
                              && (!m_ctrl[n][2] || rise) && (!m_ctrl[n][5] || ptick);
        automatic bit wcurr = hit && off == 1;
        automatic bit fire  = tick && m_curr[n] == 1 && !wcurr;
        if (wcurr)     m_curr[n] <= PWDATA & MASK;
        else if (tick) m_curr[n] <= (m_curr[n] == 0) ? m_reload[n] : m_curr[n] - 1;
        if (hit && off == 2) m_reload[n] <= PWDATA & MASK;
        if (hit && off == 0)             m_ctrl[n] <= PWDATA[5:0];
        else if (fire && m_ctrl[n][4])   m_ctrl[n][0] <= 1'b0;
        if (fire)                                 m_ist[n] <= 1'b1;
        else if (hit && off == 3 && PWDATA[0])    m_ist[n] <= 1'b0;
      end
      if (wr_now && PADDR == 10'h040) begin
        m_presc <= PWDATA & PMASK;
        m_pcnt  <= 0;
      end else begin
        m_pcnt <= ptick ? 0 : m_pcnt + 1;
      end
      m_s1 <= EXTIN; m_s2 <= m_s1; m_d <= m_s2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per APB access phase; checks interrupts every cycle.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: access seen with no expectation at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("prdata", PRDATA, mon_e[31:0]);
        chk("pslverr", 32'(PSLVERR), 32'(mon_e[32]));
        chk("pready", 32'(PREADY), 32'd1);
      end
    end else begin
      chk("idle_prdata", PRDATA, 32'd0);
      chk("idle_pslverr", 32'(PSLVERR), 32'd0);
    end
    chk("timerint", 32'(TIMERINT), 32'(m_tint()));
    chk("timerint_any", 32'(TIMERINT_ANY), 32'(|m_tint()));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_cycle(input logic wr, input logic [11:0] ba, input logic [31:0] d,
                           input bit use_exp, input logic [32:0] exp);
    logic [32:0] tmp;
    PSEL = 1'b1; PWRITE = wr; PADDR = ba[11:2]; PWDATA = d; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    tmp = model_read(ba);
    if (use_exp) sb.push_back(exp);
    else if (wr) sb.push_back({tmp[32], 32'd0});
    else         sb.push_back(tmp);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [11:0] ba, input logic [31:0] d);
    apb_cycle(1'b1, ba, d, 1'b0, '0);
  endtask

  task automatic apb_read(input logic [11:0] ba);
    apb_cycle(1'b0, ba, 32'd0, 1'b0, '0);
  endtask

  task automatic apb_read_exp(input logic [11:0] ba, input logic [31:0] d, input logic err);
    apb_cycle(1'b0, ba, 32'd0, 1'b1, {err, d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    idle(1);
    apb_read_exp(12'h000, 32'd0, 1'b0);
    apb_read_exp(12'h104, 32'd0, 1'b0);
    apb_read_exp(12'h034, 32'd0, 1'b0);

    // Periodic channel 0
    apb_write(12'h008, 3);
    apb_write(12'h004, 3);
    apb_write(12'h000, 32'h09);
    repeat (3) apb_read(12'h004);
    idle(6);
    apb_read_exp(12'h00C, 32'd1, 1'b0);
    apb_write(12'h000, 32'h08);
    apb_write(12'h00C, 1);
    apb_read_exp(12'h00C, 32'd0, 1'b0);

    // One-shot channel 1
    apb_write(12'h014, 2);
    apb_write(12'h010, 32'h19);
    idle(20);
    apb_read_exp(12'h010, 32'h18, 1'b0);
    apb_read_exp(12'h014, 32'd0, 1'b0);
    apb_read_exp(12'h01C, 32'd1, 1'b0);
    apb_write(12'h01C, 1);
    apb_write(12'h010, 0);

    // Prescaled channel 2
    apb_write(12'h100, 3);
    apb_write(12'h024, 2);
    apb_write(12'h020, 32'h21);
    repeat (4) apb_read(12'h024);
    idle(6);
    apb_read_exp(12'h02C, 32'd1, 1'b0);
    apb_read_exp(12'h024, 32'd0, 1'b0);
    apb_write(12'h020, 0);
    apb_write(12'h02C, 1);
    apb_write(12'h100, 0);

    // External clock channel 3
    apb_write(12'h030, 32'h05);
    apb_write(12'h034, 5);
    for (int p = 0; p < 2; p++) begin
      EXTIN[3] = 1'b1; idle(5);
      EXTIN[3] = 1'b0; idle(5);
    end
    EXTIN[3] = 1'b1;
    idle(20);
    apb_read_exp(12'h034, 32'd2, 1'b0);
    EXTIN[3] = 1'b0;
    apb_write(12'h030, 0);

    // CURR write colliding with a 1->0 tick on channel 0
    apb_write(12'h000, 32'h0B);
    apb_write(12'h004, 1);
    idle(3);
    EXTIN[0] = 1'b1; idle(1);
    EXTIN[0] = 1'b0;
    apb_write(12'h004, 32'h10);
    apb_read_exp(12'h004, 32'h10, 1'b0);
    apb_read_exp(12'h00C, 32'd0, 1'b0);

    // W1C colliding with the interrupt-setting tick
    apb_write(12'h004, 1);
    idle(2);
    EXTIN[0] = 1'b1; idle(1);
    EXTIN[0] = 1'b0;
    apb_write(12'h00C, 1);
    apb_read_exp(12'h00C, 32'd1, 1'b0);
    apb_read_exp(12'h004, 32'd0, 1'b0);
    apb_write(12'h00C, 1);
    apb_read_exp(12'h00C, 32'd0, 1'b0);
    apb_write(12'h000, 0);

    // Decode and width truncation
    apb_read_exp(12'h040, 32'd0, 1'b1);
    apb_read_exp(12'h108, 32'd0, 1'b1);
    apb_read_exp(12'h3FC, 32'd0, 1'b1);
    apb_write(12'h040, 32'hFFFF_FFFF);
    apb_write(12'h008, 32'hFFFF_FFFF);
    apb_read_exp(12'h008, 32'h0000_FFFF, 1'b0);
    apb_write(12'h010, 32'hFFFF_FFC0);
    apb_read_exp(12'h010, 32'd0, 1'b0);

    // Random traffic
    for (int t = 0; t < 250; t++) begin
      automatic int          kind = int'($urandom_range(0, 9));
      automatic logic [11:0] ba;
      automatic logic [31:0] d;
      if (kind < 8)       ba = {4'd0, 4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'b00};
      else if (kind == 8) ba = ($urandom_range(0, 1) == 0) ? 12'h100 : 12'h104;
      else                ba = {10'($urandom), 2'b00};
      d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7);
      if (ba < 12'h100 && ba[3:2] == 2'd0) d = $urandom;
      EXTIN = NCH'($urandom);
      if ($urandom_range(0, 2) == 0) apb_read(ba);
      else                           apb_write(ba, d);
      repeat ($urandom_range(0, 2)) begin
        EXTIN = NCH'($urandom);
        idle(1);
      end
    end
    EXTIN = '0;

    // Reset asserted mid-count
    apb_write(12'h008, 2);
    apb_write(12'h004, 2);
    apb_write(12'h000, 32'h09);
    idle(6);
    chk("pre_reset_int0", 32'(TIMERINT[0]), 32'd1);
    #3 PRESETn = 1'b0;
    #1;
    chk("reset_timerint", 32'(TIMERINT), 32'd0);
    chk("reset_timerint_any", 32'(TIMERINT_ANY), 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_pslverr", 32'(PSLVERR), 32'd0);
    repeat (2) @(posedge PCLK);
    #2 PRESETn = 1'b1;
    idle(1);
    apb_read_exp(12'h004, 32'd0, 1'b0);
    apb_read_exp(12'h000, 32'd0, 1'b0);
    apb_read_exp(12'h100, 32'd0, 1'b0);
    idle(2);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d expectations never matched, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
